// File: rtl/alu_1_if.sv
// ALU operand/result bus: the master drives operands and op, the slave returns result and flags.
interface alu_1_if #(
   parameter int unsigned WIDTH = 4
) ();

   logic [WIDTH-1:0] inA;
   logic [WIDTH-1:0] inB;
   logic [1:0]       op;
   logic [WIDTH-1:0] ans;
   logic             zero;
   logic             carry;
   logic             ovf;

   modport master (
      output inA, inB, op,
      input  ans, zero, carry, ovf
   );

   modport slave (
      input  inA, inB, op,
      output ans, zero, carry, ovf
   );

endinterface

// File: rtl/alu_1.sv
// Registered WIDTH-bit ALU: add, subtract, AND, OR with zero/carry/overflow flags.
// Result and flags are captured together one clock after the operands are sampled.
module alu_1 #(
   parameter int unsigned WIDTH = 4
) (
   input  logic    clk,
   input  logic    reset,
   alu_1_if.slave  bus
);

   localparam int unsigned MSB = WIDTH - 1;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_OR  = 2'b11;

   logic [WIDTH:0]   w_add;
   logic [WIDTH:0]   w_sub;
   logic [WIDTH-1:0] w_ans;
   logic             w_carry;
   logic             w_ovf;
   logic             w_zero;
   logic             w_a_msb;
   logic             w_b_msb;

   logic [WIDTH-1:0] r_ans;
   logic             r_zero;
   logic             r_carry;
   logic             r_ovf;

   // Next result/flags; arithmetic is one bit wider so the top bit yields carry or borrow.
   always_comb begin
      w_add   = {1'b0, bus.inA} + {1'b0, bus.inB};
      w_sub   = {1'b0, bus.inA} + {1'b0, ~bus.inB} + {{WIDTH{1'b0}}, 1'b1};
      w_a_msb = bus.inA[MSB];
      w_b_msb = bus.inB[MSB];
      w_ans   = bus.inA | bus.inB;
      w_carry = 1'b0;
      w_ovf   = 1'b0;
      case (bus.op)
         OP_ADD: begin
            w_ans   = w_add[WIDTH-1:0];
            w_carry = w_add[WIDTH];
            w_ovf   = (w_a_msb == w_b_msb) && (w_add[MSB] != w_a_msb);
         end
         OP_SUB: begin
            w_ans   = w_sub[WIDTH-1:0];
            w_carry = ~w_sub[WIDTH];
            w_ovf   = (w_a_msb != w_b_msb) && (w_sub[MSB] != w_a_msb);
         end
         OP_AND: w_ans = bus.inA & bus.inB;
         OP_OR:  w_ans = bus.inA | bus.inB;
         default: w_ans = bus.inA | bus.inB;
      endcase
      w_zero = (w_ans == '0);
   end

   // Capture result and flags together; reset wins over any operation.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ans   <= '0;
         r_zero  <= 1'b1;
         r_carry <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_ans   <= w_ans;
         r_zero  <= w_zero;
         r_carry <= w_carry;
         r_ovf   <= w_ovf;
      end
   end

   assign bus.ans   = r_ans;
   assign bus.zero  = r_zero;
   assign bus.carry = r_carry;
   assign bus.ovf   = r_ovf;

endmodule

// File: tb/tb_alu_1.sv
// Bench for alu_1: expected results are queued when operands are driven and
// compared when the registered output appears after the next rising edge.
module tb_alu_1;

   localparam int unsigned WIDTH = 4;
   localparam logic [6:0]  RST_EXP = 7'b0000_100;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   alu_1_if #(.WIDTH(WIDTH)) bus ();

   alu_1 #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;
   logic [6:0] exp_q[$];
   logic [6:0] mon_e;

   // Single comparison point: counts every check and reports mismatches.
   task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model built on signed/unsigned integer arithmetic: {ans, zero, carry, ovf}.
   function automatic logic [6:0] model(input logic [3:0] a, input logic [3:0] b,
                                        input logic [1:0] o);
      int ia, ib, sa, sb, r;
      logic [3:0] ans;
      logic c, v;
      ia = int'(a);
      ib = int'(b);
      sa = a[3] ? ia - 16 : ia;
      sb = b[3] ? ib - 16 : ib;
      c = 1'b0;
      v = 1'b0;
      case (o)
         2'b00: begin
            ans = 4'(ia + ib);
            c   = (ia + ib) > 15;
            r   = sa + sb;
            v   = (r > 7) || (r < -8);
         end
         2'b01: begin
            ans = 4'(ia - ib);
            c   = ia < ib;
            r   = sa - sb;
            v   = (r > 7) || (r < -8);
         end
         2'b10:   ans = a & b;
         default: ans = a | b;
      endcase
      return {ans, (ans == 4'd0), c, v};
   endfunction

   // Apply one cycle of stimulus and queue what the DUT must show after the next edge.
   task automatic drive(input logic r, input logic [3:0] a, input logic [3:0] b,
                        input logic [1:0] o);
      @(negedge clk);
      reset   = r;
      bus.inA = a;
      bus.inB = b;
      bus.op  = o;
      exp_q.push_back(r ? RST_EXP : model(a, b, o));
   endtask

   // Output monitor: pop one expectation per edge once stimulus is in flight.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         check("ans",   {3'b000, bus.ans}, {3'b000, mon_e[6:3]});
         check("flags", {4'b0000, bus.zero, bus.carry, bus.ovf}, {4'b0000, mon_e[2:0]});
      end
   end

   initial begin
      reset   = 1'b1;
      bus.inA = '0;
      bus.inB = '0;
      bus.op  = 2'b00;

      // Reset held two cycles.
      drive(1'b1, 4'b0000, 4'b0000, 2'b00);
      drive(1'b1, 4'b0000, 4'b0000, 2'b00);

      // Deassert reset; outputs must still hold reset values before the next edge.
      drive(1'b0, 4'b0010, 4'b1110, 2'b11);
      #1;
      check("hold", {bus.ans, bus.zero, bus.carry, bus.ovf}, RST_EXP);

      // Add boundaries.
      drive(1'b0, 4'b1111, 4'b0001, 2'b00);
      drive(1'b0, 4'b0111, 4'b0001, 2'b00);
      // Subtract boundaries and a plain case.
      drive(1'b0, 4'b0000, 4'b0001, 2'b01);
      drive(1'b0, 4'b0101, 4'b0011, 2'b01);
      drive(1'b0, 4'b1000, 4'b0001, 2'b01);
      // AND.
      drive(1'b0, 4'b1100, 4'b1010, 2'b10);
      drive(1'b0, 4'b0101, 4'b1010, 2'b10);

      // Op changes every cycle with a reset in the middle.
      drive(1'b0, 4'b0011, 4'b0100, 2'b00);
      drive(1'b0, 4'b1001, 4'b0110, 2'b01);
      drive(1'b1, 4'b1111, 4'b1111, 2'b10);
      drive(1'b0, 4'b1010, 4'b0100, 2'b11);
      drive(1'b0, 4'b0110, 4'b0011, 2'b00);

      // Random traffic.
      for (int i = 0; i < 40; i++) begin
         drive(1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               2'($urandom_range(0, 3)));
      end

      // Drain the scoreboard with a bounded wait.
      for (int w = 0; w < 5 && exp_q.size() > 0; w++) begin
         @(negedge clk);
      end
      if (exp_q.size() > 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
